pgm_stream_tx: RTL and testbench
================================

PGM_STREAM_TX -- requirements
Module: pgm_stream_tx

Interface
REQ-001 Parameter DIM_W, default 12, sets the width of the column and row dimensions in bits.
REQ-002 Parameter PIX_W, default 8, sets the width of pixel data and maxval in bits.
REQ-003 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; assertion (0) SHALL clear state immediately, independent of clock.
REQ-005 start  input  1  one-cycle request to begin a frame; sampled only in IDLE.
REQ-006 cols, rows  input  DIM_W each  frame dimensions; SHALL be latched on an accepted start.
REQ-007 maxval  input  PIX_W  header maximum gray value; SHALL be latched on an accepted start.
REQ-008 pix_valid / pix_data  input  1 / PIX_W  upstream pixel stream.
REQ-009 pix_ready  output  1  pixel accepted when pix_valid and pix_ready are both 1 in the same cycle.
REQ-010 out_valid / out_data / out_last  output  1 / 32 / 1  serialized PGM word stream; out_last marks the final word of a frame.
REQ-011 out_ready  input  1  downstream accepts a word when out_valid and out_ready are both 1.
REQ-012 busy / done  output  1 / 1  busy while a frame is in progress; done is a one-cycle pulse at frame end.

Function
REQ-013 The FSM SHALL have states IDLE, MAGIC, COLS, ROWS, MAXV, PIX and DONE.
REQ-014 In IDLE, start=1 SHALL latch cols, rows and maxval, load pixel count = cols*rows (2*DIM_W bits), move to MAGIC and set busy=1 on the next cycle.
REQ-015 In MAGIC, COLS, ROWS and MAXV, the block SHALL drive out_valid=1 with, in order: 32'h0000_5032 ("P2"), cols zero-extended, rows zero-extended, and maxval zero-extended; each state SHALL advance only on an out handshake.
REQ-016 In MAXV with pixel count 0, the maxval word SHALL carry out_last=1, and the FSM SHALL go to DONE after the handshake, skipping PIX.
REQ-017 In PIX, pix_ready SHALL equal (!out_valid || out_ready) and SHALL be 0 in every other state.
REQ-018 An accepted pixel SHALL appear on out_data, zero-extended, in the next cycle (1-cycle latency); with back-to-back handshakes the throughput SHALL be one word per clock.
REQ-019 The pixel counter SHALL decrement on each accepted pixel; the last pixel's word SHALL carry out_last=1.
REQ-020 After the last word's out handshake, the FSM SHALL go to DONE, and no further pixel SHALL be accepted.
REQ-021 In DONE, the block SHALL pulse done=1 for exactly one cycle, deassert busy and return to IDLE.
REQ-022 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-023 start while busy SHALL be ignored, and changes to cols, rows or maxval mid-frame SHALL have no effect.
REQ-024 If start arrives in the same cycle as done, it SHALL be ignored; a new start is accepted only in IDLE.
REQ-025 The product cols*rows SHALL be computed without truncation (4095*4095 is legal).

Reset
REQ-026 On reset=0, the FSM SHALL enter IDLE and the pixel counter and latched header registers SHALL clear to 0.
REQ-027 On reset=0, outputs SHALL be out_valid=0, out_data=0, out_last=0, pix_ready=0, busy=0 and done=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame and drop any pending output word, with no done pulse.
REQ-029 Operation SHALL resume on the first rising clock edge after reset returns to 1.

Configuration
REQ-030 With macro PGM_TX_CLAMP_EN defined, a pixel greater than the latched maxval SHALL be emitted as maxval (saturation).
REQ-031 Without PGM_TX_CLAMP_EN, pixels SHALL pass through unmodified, and the clamp comparator SHALL be absent.

Verification
REQ-032 Scenario (header): start with cols=2, rows=2, maxval=255 and out_ready held at 1 -> words 0x5032, 2, 2, 255 on consecutive cycles, then 4 pixels, last=1 on the 4th, and done pulses once.
REQ-033 Scenario (backpressure): 3x1 frame, pixels 10, 20, 30, with out_ready toggling 1010 -> output holds stable while stalled, pix_ready=0 during stall, and output order is preserved.
REQ-034 Scenario (zero frame): cols=0, rows=5 -> exactly 4 header words, last=1 on the maxval word, and no pix_ready pulse.
REQ-035 Scenario (clamp): maxval=200, pixel 250 -> out_data=200 with PGM_TX_CLAMP_EN defined, or 250 without it.
REQ-036 Scenario (reset mid-frame): reset=0 during PIX with 3 pixels sent -> all outputs 0 immediately and no done pulse; a fresh start then produces a complete frame from 0x5032.
REQ-037 Scenario (busy start): start pulsed during ROWS with new dimensions -> ignored, and the frame completes with the original dimensions.

Source files
------------

// File: rtl/pgm_stream_tx.sv
// -----------------------------------------------------------------------------
// pgm_stream_tx
//
// Serializes one grayscale frame as a stream of 32-bit words in plain PGM
// ("P2") order: magic word, width, height and maxval, then one word per
// pixel. The upstream pixel stream and the downstream word stream are both
// valid/ready.
//
// Handshake rule (both streams): a transfer happens on a rising clock edge
// where valid and ready are both 1. A producer holding valid=1 keeps its
// data/last stable until that transfer, and ready never depends on the
// partner's valid.
//
// Optional feature, selected at build time:
//   PGM_TX_CLAMP_EN  - pixels above the latched maxval are saturated to maxval.
//                      When undefined, pixels pass through untouched and no
//                      comparator is built.
//
// Ports:
//   clock               rising-edge clock
//   reset               asynchronous active-low reset
//   start               one-cycle frame request, honoured only in IDLE
//   cols, rows          frame dimensions, latched on an accepted start
//   maxval              header maximum gray value, latched on an accepted start
//   pix_valid/pix_data  upstream pixel stream
//   pix_ready           upstream ready (only ever high in PIX)
//   out_valid/out_data  downstream word stream
//   out_last            marks the final word of a frame
//   out_ready           downstream ready
//   busy                high while a frame is in progress
//   done                one-cycle pulse at frame end
//   dbg_state           current FSM state encoding, for observation only
// -----------------------------------------------------------------------------
module pgm_stream_tx #(
  parameter int DIM_W = 12,
  parameter int PIX_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [DIM_W-1:0] cols,
  input  logic [DIM_W-1:0] rows,
  input  logic [PIX_W-1:0] maxval,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  output logic             pix_ready,
  output logic             out_valid,
  output logic [31:0]      out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [2:0]       dbg_state
);

  localparam int          CNT_W      = 2 * DIM_W;
  localparam logic [31:0] MAGIC_WORD = 32'h0000_5032;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MAGIC = 3'd1,
    COLS  = 3'd2,
    ROWS  = 3'd3,
    MAXV  = 3'd4,
    PIX   = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t             state;
  logic [DIM_W-1:0]   cols_q;
  logic [DIM_W-1:0]   rows_q;
  logic [PIX_W-1:0]   maxval_q;
  // Pixels still to be accepted; double width so cols*rows never truncates.
  logic [CNT_W-1:0]   pix_cnt;
  logic [PIX_W-1:0]   pix_word;
  logic               out_hs;
  logic               pix_hs;

  assign dbg_state = state;
  assign out_hs    = out_valid && out_ready;

  // The output register can take a new pixel when it is empty or draining
  // this cycle. Once the counter reaches zero the last word is already
  // queued, so nothing more is accepted while it waits to leave.
  assign pix_ready = (state == PIX) && (pix_cnt != '0) && (!out_valid || out_ready);
  assign pix_hs    = pix_valid && pix_ready;

`ifdef PGM_TX_CLAMP_EN
  always_comb begin
    pix_word = pix_data;
    if (pix_data > maxval_q) begin
      pix_word = maxval_q;
    end
  end
`else
  always_comb begin
    pix_word = pix_data;
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cols_q    <= '0;
      rows_q    <= '0;
      maxval_q  <= '0;
      pix_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cols_q    <= cols;
            rows_q    <= rows;
            maxval_q  <= maxval;
            pix_cnt   <= CNT_W'(cols) * CNT_W'(rows);
            busy      <= 1'b1;
            // The magic word is loaded here so it is presented in MAGIC.
            out_valid <= 1'b1;
            out_data  <= MAGIC_WORD;
            out_last  <= 1'b0;
            state     <= MAGIC;
          end
        end

        MAGIC: begin
          if (out_hs) begin
            out_data <= 32'(cols_q);
            state    <= COLS;
          end
        end

        COLS: begin
          if (out_hs) begin
            out_data <= 32'(rows_q);
            state    <= ROWS;
          end
        end

        ROWS: begin
          if (out_hs) begin
            out_data <= 32'(maxval_q);
            // An empty frame ends on its header.
            out_last <= (pix_cnt == '0);
            state    <= MAXV;
          end
        end

        MAXV: begin
          if (out_hs) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (pix_cnt == '0) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= PIX;
            end
          end
        end

        PIX: begin
          if (out_hs && out_last) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else if (pix_hs) begin
            // Covers both an empty register and a drain-and-refill in the
            // same cycle, giving one word per clock under full throughput.
            out_valid <= 1'b1;
            out_data  <= 32'(pix_word);
            out_last  <= (pix_cnt == CNT_W'(1));
            pix_cnt   <= pix_cnt - CNT_W'(1);
          end else if (out_hs) begin
            out_valid <= 1'b0;
          end
        end

        DONE: begin
          // done is high for this single cycle; start is not looked at here.
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pgm_stream_tx.sv
module tb_pgm_stream_tx;

  localparam int DIM_W = 12;
  localparam int PIX_W = 8;

  // ---------------- clock / reset ----------------
  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [DIM_W-1:0] cols = '0;
  logic [DIM_W-1:0] rows = '0;
  logic [PIX_W-1:0] maxval = '0;
  logic             pix_valid = 1'b0;
  logic [PIX_W-1:0] pix_data = '0;
  logic             pix_ready;
  logic             out_valid;
  logic [31:0]      out_data;
  logic             out_last;
  logic             out_ready = 1'b0;
  logic             busy;
  logic             done;
  logic [2:0]       dbg_state;

  always #5 clock = ~clock;

  pgm_stream_tx #(.DIM_W(DIM_W), .PIX_W(PIX_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .cols     (cols),
    .rows     (rows),
    .maxval   (maxval),
    .pix_valid(pix_valid),
    .pix_data (pix_data),
    .pix_ready(pix_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done),
    .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int passed = 0;
  int done_cnt = 0;
  int rdy_mode = 0;   // 0: always ready, 1: mostly ready, 2: toggle, 3: coin flip
  bit pix_seen = 1'b0;

  logic [32:0]      exp_q[$];   // {last, data}
  logic [PIX_W-1:0] px_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [PIX_W-1:0] ref_pix(input logic [PIX_W-1:0] p, input logic [PIX_W-1:0] m);
`ifdef PGM_TX_CLAMP_EN
    return (p > m) ? m : p;
`else
    return p;
`endif
  endfunction

  // A frame is the magic word, three header values and one word per pixel;
  // the final word of the frame carries last.
  task automatic push_frame(input logic [DIM_W-1:0] c, input logic [DIM_W-1:0] r,
                            input logic [PIX_W-1:0] m);
    int n;
    n = int'(c) * int'(r);
    exp_q.push_back({1'b0, 32'h0000_5032});
    exp_q.push_back({1'b0, 32'(c)});
    exp_q.push_back({1'b0, 32'(r)});
    exp_q.push_back({(n == 0), 32'(m)});
    for (int i = 0; i < n; i++)
      exp_q.push_back({(i == n - 1), 32'(ref_pix(px_q[i], m))});
  endtask

  // ---------------- downstream ready driver ----------------
  initial begin
    forever begin
      @(posedge clock);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        2:       out_ready = ~out_ready;
        default: out_ready = $urandom_range(0, 1) == 1;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit          prev_stall;
    bit          prev_done;
    logic [32:0] prev_word;
    logic [32:0] exp_w;
    prev_stall = 1'b0;
    prev_done  = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev_stall = 1'b0;
        prev_done  = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_hold_valid", out_valid, 1);
          check("stall_hold_word", {out_last, out_data}, prev_word);
        end
        if (out_valid && !out_ready) check("stall_pix_ready", pix_ready, 0);
        if (out_valid && out_ready) begin
          check("word_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            exp_w = exp_q.pop_front();
            check("out_word", {out_last, out_data}, exp_w);
          end
        end
        if (done) begin
          done_cnt++;
          check("done_one_cycle", prev_done, 0);
        end
        if (pix_ready) pix_seen = 1'b1;
        prev_done  = done;
        prev_stall = out_valid && !out_ready;
        prev_word  = {out_last, out_data};
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_start(input logic [DIM_W-1:0] c, input logic [DIM_W-1:0] r,
                            input logic [PIX_W-1:0] m);
    @(posedge clock);
    #1;
    start  = 1'b1;
    cols   = c;
    rows   = r;
    maxval = m;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Sends up to cnt pixels from px_q starting at index first; returns how many went.
  task automatic send_pixels(input int first, input int cnt, input int gap_pct, output int sent);
    bit acc;
    sent = 0;
    for (int i = first; i < first + cnt; i++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        pix_valid = 1'b0;
        pix_data  = PIX_W'($urandom);
        @(posedge clock);
        #1;
      end
      pix_valid = 1'b1;
      pix_data  = px_q[i];
      acc = 1'b0;
      for (int t = 0; t < 400 && !acc; t++) begin
        @(negedge clock);
        acc = pix_ready;
        @(posedge clock);
        #1;
      end
      if (!acc) begin
        check("pix_accept_timeout", 0, 1);
        break;
      end
      sent++;
    end
    pix_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [DIM_W-1:0] c, input logic [DIM_W-1:0] r,
                           input logic [PIX_W-1:0] m, input int mode, input int gap_pct,
                           input bit use_given, input bit busy_start);
    int n;
    int d0;
    int sent;
    n = int'(c) * int'(r);
    if (!use_given) begin
      px_q.delete();
      for (int i = 0; i < n; i++) px_q.push_back(PIX_W'($urandom_range(0, 255)));
    end
    push_frame(c, r, m);
    rdy_mode = mode;
    pix_seen = 1'b0;
    d0 = done_cnt;
    send_start(c, r, m);
    check("busy_after_start", busy, 1);
    if (busy_start) begin
      // Two edges after acceptance the header sits in ROWS under full ready.
      repeat (2) @(posedge clock);
      #1;
      start  = 1'b1;
      cols   = c + DIM_W'(5);
      rows   = r + DIM_W'(3);
      maxval = ~m;
      @(posedge clock);
      #1;
      start = 1'b0;
    end
    send_pixels(0, n, gap_pct, sent);
    for (int t = 0; t < 2000 && done_cnt == d0; t++) begin
      @(posedge clock);
      #1;
    end
    check("done_seen", done_cnt - d0, 1);
    repeat (3) @(posedge clock);
    #1;
    check("done_once", done_cnt - d0, 1);
    check("queue_drained", exp_q.size(), 0);
    check("busy_cleared", busy, 0);
    if (n == 0) check("zero_frame_no_pix_ready", pix_seen, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_pix_ready"}, pix_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int sent;
    int d0;

    repeat (3) @(posedge clock);
    #1;
    check_outputs_zero("reset");
    reset = 1'b1;

    // 2x2 header frame at full throughput.
    run_frame(12'd2, 12'd2, 8'd255, 0, 0, 1'b0, 1'b0);

    // Backpressure with out_ready toggling.
    px_q = '{8'd10, 8'd20, 8'd30};
    run_frame(12'd3, 12'd1, 8'd255, 2, 0, 1'b1, 1'b0);

    // Empty frame: header only.
    run_frame(12'd0, 12'd5, 8'd77, 1, 0, 1'b0, 1'b0);

    // Saturation case.
    px_q = '{8'd250};
    run_frame(12'd1, 12'd1, 8'd200, 0, 0, 1'b1, 1'b0);

    // Start during the header with different inputs must not disturb the frame.
    run_frame(12'd2, 12'd3, 8'd99, 0, 0, 1'b0, 1'b1);

    // Reset in the middle of the pixel phase.
    px_q.delete();
    for (int i = 0; i < 10; i++) px_q.push_back(PIX_W'($urandom_range(0, 255)));
    push_frame(12'd5, 12'd2, 8'd180);
    rdy_mode = 0;
    d0 = done_cnt;
    send_start(12'd5, 12'd2, 8'd180);
    send_pixels(0, 3, 0, sent);
    check("reset_pixels_sent", sent, 3);
    reset = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    exp_q.delete();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("mid_reset_no_done", done_cnt - d0, 0);
    run_frame(12'd4, 12'd2, 8'd128, 1, 20, 1'b0, 1'b0);

    // Randomised frames.
    for (int k = 0; k < 8; k++) begin
      run_frame(DIM_W'($urandom_range(0, 6)), DIM_W'($urandom_range(0, 6)),
                PIX_W'($urandom_range(0, 255)), $urandom_range(0, 3),
                $urandom_range(0, 40), 1'b0, 1'b0);
    end

    // Pixel count wider than one dimension.
    run_frame(12'd65, 12'd65, 8'd255, 0, 0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
